// File: rtl/masked_lane_accumulator.sv
// Masked lane accumulator: adds the masked lanes of a latched word, one lane per clock.
// Reports sum, lane count and sticky carry through a start/busy/done handshake.
module masked_lane_accumulator #(
  parameter int LANE_W = 8,
  parameter int LANES  = 8,
  parameter int ACC_W  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [LANES*LANE_W-1:0]      data,
  input  logic [LANES-1:0]             mask,
  output logic                         busy,
  output logic                         done,
  output logic [ACC_W-1:0]             result,
  output logic [$clog2(LANES+1)-1:0]   count,
  output logic                         overflow
);

  localparam int CW = $clog2(LANES + 1);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW = ACC_W + 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nx;
  logic                      w_accept;
  logic                      w_last;

  logic [LANES*LANE_W-1:0]   r_data;
  logic [LANES-1:0]          r_mask;
  logic [ACC_W-1:0]          r_acc;
  logic [IW-1:0]             r_idx;
  logic [CW-1:0]             r_cnt;
  logic                      r_ovf;
  logic                      r_done;
  logic [ACC_W-1:0]          r_result;
  logic [CW-1:0]             r_count;
  logic                      r_overflow;

  logic [LANE_W-1:0]         w_lane;
  logic [SW-1:0]             w_sum;
  logic                      w_carry;
  logic [ACC_W-1:0]          w_acc_nx;
  logic [CW-1:0]             w_cnt_nx;
  logic                      w_ovf_nx;

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_accept   = 1'b1;
        end
      end
      S_RUN: begin
        if (r_idx == LAST) begin
          w_state_nx = S_IDLE;
          w_last     = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operands shift down each step, so the current lane is always lane 0
  assign w_lane  = r_data[LANE_W-1:0];
  assign w_sum   = {1'b0, r_acc} + SW'(w_lane);
  assign w_carry = w_sum[ACC_W];

  always_comb begin
    w_acc_nx = r_acc;
    w_cnt_nx = r_cnt;
    w_ovf_nx = r_ovf;
    if (r_mask[0]) begin
      w_acc_nx = (SAT_EN && w_carry) ? '1 : w_sum[ACC_W-1:0];
      w_cnt_nx = r_cnt + CW'(1);
      w_ovf_nx = r_ovf | w_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_mask     <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_last;
      if (w_accept) begin
        r_data <= data;
        r_mask <= mask;
        r_acc  <= '0;
        r_idx  <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_data <= r_data >> LANE_W;
        r_mask <= r_mask >> 1;
        r_acc  <= w_acc_nx;
        r_cnt  <= w_cnt_nx;
        r_ovf  <= w_ovf_nx;
        r_idx  <= r_idx + IW'(1);
      end
      if (w_last) begin
        r_result   <= w_acc_nx;
        r_count    <= w_cnt_nx;
        r_overflow <= w_ovf_nx;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign result   = r_result;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_masked_lane_accumulator.sv
// Bench for masked_lane_accumulator: wrap and saturate instances side by side,
// directed cases plus random operations against an arithmetic reference.
module tb_masked_lane_accumulator;

  localparam int LANE_W = 8;
  localparam int LANES  = 8;
  localparam int ACC_W  = 8;
  localparam int CW     = $clog2(LANES + 1);
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic [LANES*LANE_W-1:0] data;
  logic [LANES-1:0]        mask;

  logic                    busy0, done0, ovf0;
  logic [ACC_W-1:0]        res0;
  logic [CW-1:0]           cnt0;
  logic                    busy1, done1, ovf1;
  logic [ACC_W-1:0]        res1;
  logic [CW-1:0]           cnt1;

  int checks;
  int failures;

  masked_lane_accumulator #(
    .LANE_W(LANE_W), .LANES(LANES), .ACC_W(ACC_W), .SAT_EN(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .mask(mask),
    .busy(busy0), .done(done0), .result(res0), .count(cnt0),
    .overflow(ovf0)
  );

  masked_lane_accumulator #(
    .LANE_W(LANE_W), .LANES(LANES), .ACC_W(ACC_W), .SAT_EN(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .mask(mask),
    .busy(busy1), .done(done1), .result(res1), .count(cnt1),
    .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum of selected lanes with carry handling
  task automatic model(input logic [63:0] d, input logic [7:0] m,
                       input bit sat, output int res, output int cnt,
                       output int ovf);
    int acc;
    int lane;
    acc = 0;
    cnt = 0;
    ovf = 0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        lane = int'((d >> (i * LANE_W)) & 64'hFF);
        cnt++;
        acc = acc + lane;
        if (acc > MAXV) begin
          ovf = 1;
          acc = sat ? MAXV : acc - (MAXV + 1);
        end
      end
    end
    res = acc;
  endtask

  task automatic launch(input string tag, input logic [63:0] d,
                        input logic [7:0] m);
    start = 1'b1;
    data  = d;
    mask  = m;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy0"}, 64'(busy0), 64'd1);
    chk({tag, "_busy1"}, 64'(busy1), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int c0);
    int cyc;
    bit seen;
    cyc  = c0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done0) seen = 1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(LANES));
    chk({tag, "_done1"}, 64'(done1), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy0), 64'd0);
  endtask

  task automatic verify(input string tag, input logic [63:0] d,
                        input logic [7:0] m);
    int r, c, o;
    model(d, m, 1'b0, r, c, o);
    chk({tag, "_res0"}, 64'(res0), 64'(r));
    chk({tag, "_cnt0"}, 64'(cnt0), 64'(c));
    chk({tag, "_ovf0"}, 64'(ovf0), 64'(o));
    model(d, m, 1'b1, r, c, o);
    chk({tag, "_res1"}, 64'(res1), 64'(r));
    chk({tag, "_cnt1"}, 64'(cnt1), 64'(c));
    chk({tag, "_ovf1"}, 64'(ovf1), 64'(o));
  endtask

  task automatic after_done(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done0), 64'd0);
    chk({tag, "_idle"}, 64'(busy0), 64'd0);
  endtask

  initial begin
    logic [63:0] d, d2, d3;
    logic [7:0]  m, m2, m3;
    int          dseen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b1;
    data     = 64'hFFFF_FFFF_FFFF_FFFF;
    mask     = 8'hFF;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_res", 64'(res0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    d = 64'h0807060504030201;
    launch("t2", d, 8'hFF);
    wait_done("t2", 0);
    chk("t2_res_lit", 64'(res0), 64'h24);
    chk("t2_cnt_lit", 64'(cnt0), 64'd8);
    verify("t2", d, 8'hFF);
    after_done("t2");

    launch("t3a", d, 8'h05);
    wait_done("t3a", 0);
    chk("t3a_res_lit", 64'(res0), 64'h04);
    chk("t3a_cnt_lit", 64'(cnt0), 64'd2);
    verify("t3a", d, 8'h05);
    after_done("t3a");

    launch("t3b", d, 8'h00);
    wait_done("t3b", 0);
    chk("t3b_res_lit", 64'(res0), 64'h00);
    chk("t3b_cnt_lit", 64'(cnt0), 64'd0);
    verify("t3b", d, 8'h00);

    d = 64'h8080808080808080;
    launch("t4", d, 8'h03);
    wait_done("t4", 0);
    chk("t4_res_wrap", 64'(res0), 64'h00);
    chk("t4_ovf_wrap", 64'(ovf0), 64'd1);
    chk("t4_res_sat", 64'(res1), 64'hFF);
    chk("t4_ovf_sat", 64'(ovf1), 64'd1);
    verify("t4", d, 8'h03);
    after_done("t4");

    d  = {$urandom(), $urandom()};
    m  = 8'($urandom());
    d2 = {$urandom(), $urandom()};
    m2 = ~m;
    launch("t5", d, m);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    data  = d2;
    mask  = m2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_nodone_early", 64'(done0), 64'd0);
    wait_done("t5", 4);
    verify("t5", d, m);
    d3 = {$urandom(), $urandom()};
    m3 = 8'($urandom());
    launch("t5b", d3, m3);
    wait_done("t5b", 0);
    verify("t5b", d3, m3);
    after_done("t5b");

    launch("t6", d2, m2);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_busy", 64'(busy0), 64'd0);
    chk("t6_done", 64'(done0), 64'd0);
    chk("t6_res", 64'(res0), 64'd0);
    chk("t6_cnt", 64'(cnt0), 64'd0);
    dseen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done0 || done1) dseen = 1;
    end
    chk("t6_no_done", 64'(dseen), 64'd0);
    launch("t6b", d2, m2);
    wait_done("t6b", 0);
    verify("t6b", d2, m2);

    for (int k = 0; k < 8; k++) begin
      d = {$urandom(), $urandom()};
      m = 8'($urandom());
      if (k == 2) m = 8'hFF;
      launch("rnd", d, m);
      wait_done("rnd", 0);
      verify("rnd", d, m);
    end
    after_done("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
